pipe_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage static pipeline (no forwarding).

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EXE/MEM hazard inputs plus the per-stage
// write-enable / flush controls driven back into the pipeline registers.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_rs_used;
   logic        id_rt_used;
   logic [4:0]  exe_rf_waddr;
   logic        exe_rf_wena;
   logic [4:0]  mem_rf_waddr;
   logic        mem_rf_wena;
   logic        exe_mdu_start;
   logic        id_branch_taken;

   logic        pc_wena;
   logic        if_id_wena;
   logic        if_id_flush;
   logic        id_exe_wena;
   logic        id_exe_flush;
   logic        exe_mem_wena;
   logic        exe_mem_flush;
   logic        mem_wb_wena;
   logic        mdu_busy;
   logic [15:0] stall_cnt;

   // Pipeline side: presents hazard information, consumes stall/flush controls.
   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used,
      output exe_rf_waddr, exe_rf_wena, mem_rf_waddr, mem_rf_wena,
      output exe_mdu_start, id_branch_taken,
      input  pc_wena, if_id_wena, if_id_flush, id_exe_wena, id_exe_flush,
      input  exe_mem_wena, exe_mem_flush, mem_wb_wena, mdu_busy, stall_cnt
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used,
      input  exe_rf_waddr, exe_rf_wena, mem_rf_waddr, mem_rf_wena,
      input  exe_mdu_start, id_branch_taken,
      output pc_wena, if_id_wena, if_id_flush, id_exe_wena, id_exe_flush,
      output exe_mem_wena, exe_mem_flush, mem_wb_wena, mdu_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline without forwarding: RAW interlock,
// multi-cycle MUL/DIV front-end freeze, and taken-branch squash of the fetched slot.
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_LAT = 32,
   parameter int unsigned CNT_W   = 6
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {StRun, StMdu} state_e;

   localparam logic             MduMulti = (MDU_LAT > 1);
   localparam logic [CNT_W-1:0] CntInit  = (MDU_LAT > 1) ? CNT_W'(MDU_LAT - 2) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;

   logic rs_hit, rt_hit, raw, busy;
   logic pc_wena, if_id_wena, if_id_flush, id_exe_wena, id_exe_flush;
   logic exe_mem_wena, exe_mem_flush, mem_wb_wena;

   // Register $0 is hard-wired to zero, so it can never carry a dependency.
   always_comb begin
      rs_hit = hz.id_rs_used && (hz.id_rs != 5'd0) &&
               ((hz.exe_rf_wena && (hz.exe_rf_waddr == hz.id_rs)) ||
                (hz.mem_rf_wena && (hz.mem_rf_waddr == hz.id_rs)));
      rt_hit = hz.id_rt_used && (hz.id_rt != 5'd0) &&
               ((hz.exe_rf_wena && (hz.exe_rf_waddr == hz.id_rt)) ||
                (hz.mem_rf_wena && (hz.mem_rf_waddr == hz.id_rt)));
      raw    = rs_hit || rt_hit;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (hz.exe_mdu_start && MduMulti) begin
               state_d = StMdu;
               cnt_d   = CntInit;
               busy    = 1'b1;
            end
         end
         StMdu: begin
            // Final occupancy cycle (cnt==0) lets the op retire into MEM.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
               busy  = 1'b1;
            end else begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pc_wena       = 1'b1;
      if_id_wena    = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_wena   = 1'b1;
      id_exe_flush  = 1'b0;
      exe_mem_wena  = 1'b1;
      exe_mem_flush = 1'b0;
      mem_wb_wena   = 1'b1;
      if (busy) begin
         pc_wena       = 1'b0;
         if_id_wena    = 1'b0;
         id_exe_wena   = 1'b0;
         exe_mem_wena  = 1'b0;
         exe_mem_flush = 1'b1;
      end else if (raw) begin
         // Branch operands are stale while interlocked, so a taken branch waits.
         pc_wena      = 1'b0;
         if_id_wena   = 1'b0;
         id_exe_flush = 1'b1;
      end else if (hz.id_branch_taken) begin
         if_id_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_wena && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.pc_wena       = pc_wena;
   assign hz.if_id_wena    = if_id_wena;
   assign hz.if_id_flush   = if_id_flush;
   assign hz.id_exe_wena   = id_exe_wena;
   assign hz.id_exe_flush  = id_exe_flush;
   assign hz.exe_mem_wena  = exe_mem_wena;
   assign hz.exe_mem_flush = exe_mem_flush;
   assign hz.mem_wb_wena   = mem_wb_wena;
   assign hz.mdu_busy      = busy;
   assign hz.stall_cnt     = stall_cnt_q;

endmodule
